bidir_pad_ctrl: RTL and testbench

Synchronous controller sitting directly upstream of the PP3 bidirectional pad cell. It owns the pad's three control/data inputs (output data, output enable, input enable) and consumes the cell's gated input data. It sequences safe direction changes with programmable bus-turnaround gaps. It also delivers a synchronized, glitch-filtered receive value with edge pulses to fabric logic.

---
 rtl/bidir_pad_ctrl.sv | 158 +++++++++++++++
 tb/tb_bidir_pad_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl: direction sequencer and filtered receive path for the PP3
// bidirectional pad cell. Direction changes always pass through a gap where
// neither the output driver nor the input receiver is enabled.
//
// state            | meaning
// -----------------+-------------------------------------------------------
// ST_SENSE         | receiver enabled, driver off, RDY=1
// ST_TURN_TO_DRV   | both disabled for TURN_CYC cycles, RDY=0
// ST_DRIVE         | driver enabled, O_DAT follows DRV_DAT, RDY=1, MODE=1
// ST_TURN_TO_SENSE | both disabled for TURN_CYC cycles, RDY=0

module bidir_pad_ctrl #(
   parameter int TURN_CYC = 2,
   parameter int FILT_LEN = 3
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic DRV_REQ,
   input  logic DRV_DAT,
   output logic RDY,
   output logic MODE,
   output logic O_DAT,
   output logic O_EN,
   output logic I_EN,
   input  logic I_DAT,
   output logic RX_VAL,
   output logic RX_RISE,
   output logic RX_FALL
);

   typedef enum logic [1:0] {
      ST_SENSE         = 2'd0,
      ST_TURN_TO_DRV   = 2'd1,
      ST_DRIVE         = 2'd2,
      ST_TURN_TO_SENSE = 2'd3
   } state_t;

   // Turn counter is loaded with TURN_CYC-1 and the transition fires on zero,
   // giving exactly TURN_CYC cycles in each turnaround state.
   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);
   localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

   state_t     state;
   logic [3:0] turn_cnt;
   logic       sync_1;
   logic       sync_2;
   logic       vld_1;
   logic       vld_2;
   logic [3:0] filt_cnt;

   // Direction FSM; every pad control output is registered here.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_SENSE;
         turn_cnt <= '0;
         O_EN     <= 1'b0;
         O_DAT    <= 1'b0;
         I_EN     <= 1'b1;
         RDY      <= 1'b1;
         MODE     <= 1'b0;
      end else begin
         case (state)
            ST_SENSE: begin
               if (DRV_REQ) begin
                  state    <= ST_TURN_TO_DRV;
                  I_EN     <= 1'b0;
                  RDY      <= 1'b0;
                  turn_cnt <= TURN_LOAD;
               end
            end
            ST_TURN_TO_DRV: begin
               if (turn_cnt == 4'd0) begin
                  state <= ST_DRIVE;
                  O_EN  <= 1'b1;
                  MODE  <= 1'b1;
                  RDY   <= 1'b1;
                  O_DAT <= DRV_DAT;
               end else begin
                  turn_cnt <= turn_cnt - 4'd1;
               end
            end
            ST_DRIVE: begin
               if (DRV_REQ) begin
                  O_DAT <= DRV_DAT;
               end else begin
                  state    <= ST_TURN_TO_SENSE;
                  O_EN     <= 1'b0;
                  O_DAT    <= 1'b0;
                  MODE     <= 1'b0;
                  RDY      <= 1'b0;
                  turn_cnt <= TURN_LOAD;
               end
            end
            ST_TURN_TO_SENSE: begin
               if (turn_cnt == 4'd0) begin
                  state <= ST_SENSE;
                  I_EN  <= 1'b1;
                  RDY   <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt - 4'd1;
               end
            end
            default: begin
               state    <= ST_SENSE;
               turn_cnt <= '0;
               O_EN     <= 1'b0;
               O_DAT    <= 1'b0;
               I_EN     <= 1'b1;
               RDY      <= 1'b1;
               MODE     <= 1'b0;
            end
         endcase
      end
   end

   // Two-flop synchronizer for pad data, with a matching pipe tagging each
   // sample with the receiver enable that was present when it was captured.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         vld_1  <= 1'b0;
         vld_2  <= 1'b0;
      end else begin
         sync_1 <= I_DAT;
         sync_2 <= sync_1;
         vld_1  <= I_EN;
         vld_2  <= vld_1;
      end
   end

   // Glitch filter: RX_VAL flips only after FILT_LEN consecutive valid
   // samples that disagree with it; anything else restarts the run.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         filt_cnt <= '0;
         RX_VAL   <= 1'b0;
         RX_RISE  <= 1'b0;
         RX_FALL  <= 1'b0;
      end else begin
         RX_RISE <= 1'b0;
         RX_FALL <= 1'b0;
         if (vld_2 && (sync_2 != RX_VAL)) begin
            if (filt_cnt == FILT_LAST) begin
               filt_cnt <= '0;
               RX_VAL   <= sync_2;
               RX_RISE  <= sync_2;
               RX_FALL  <= ~sync_2;
            end else begin
               filt_cnt <= filt_cnt + 4'd1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Bench for bidir_pad_ctrl: directed stimulus, a behavioural reference model
// compared on every falling edge, and hand-computed spot checks.
module tb_bidir_pad_ctrl;

   localparam int TURN_CYC = 2;
   localparam int FILT_LEN = 3;

   logic CLK;
   logic RST_N;
   logic DRV_REQ;
   logic DRV_DAT;
   logic RDY;
   logic MODE;
   logic O_DAT;
   logic O_EN;
   logic I_EN;
   logic I_DAT;
   logic RX_VAL;
   logic RX_RISE;
   logic RX_FALL;
   logic pad;

   int checks   = 0;
   int failures = 0;

   // pad cell: input data reads 0 while the receiver is disabled
   assign I_DAT = I_EN ? pad : 1'b0;

   bidir_pad_ctrl #(.TURN_CYC(TURN_CYC), .FILT_LEN(FILT_LEN)) dut (
      .CLK(CLK), .RST_N(RST_N), .DRV_REQ(DRV_REQ), .DRV_DAT(DRV_DAT),
      .RDY(RDY), .MODE(MODE), .O_DAT(O_DAT), .O_EN(O_EN), .I_EN(I_EN),
      .I_DAT(I_DAT), .RX_VAL(RX_VAL), .RX_RISE(RX_RISE), .RX_FALL(RX_FALL)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: direction is "which side owns the pad" plus the number
   // of quiet cycles still owed; receive side is a 2-deep delay line feeding
   // a run-length rule.
   logic   m_drive;
   int     m_gap;
   logic   m_odat;
   logic   m_rx;
   int     m_run;
   logic   m_rise;
   logic   m_fall;
   logic [1:0] m_pipe[$];

   function automatic logic m_stable();
      return (m_gap == 0);
   endfunction
   function automatic logic m_ien();
      return (!m_drive && m_gap == 0);
   endfunction
   function automatic logic m_oen();
      return (m_drive && m_gap == 0);
   endfunction

   task automatic model_reset();
      m_drive = 1'b0;
      m_gap   = 0;
      m_odat  = 1'b0;
      m_rx    = 1'b0;
      m_run   = 0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_pipe  = {2'b00, 2'b00};
   endtask

   task automatic model_step();
      logic [1:0] s;
      logic       en_now;
      en_now = m_ien();
      s = m_pipe.pop_front();
      m_pipe.push_back({en_now, en_now & pad});
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s[1] && (s[0] != m_rx)) begin
         m_run = m_run + 1;
         if (m_run == FILT_LEN) begin
            m_rx   = s[0];
            m_rise = s[0];
            m_fall = !s[0];
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      if (m_gap == 0) begin
         if (m_drive) begin
            if (DRV_REQ) m_odat = DRV_DAT;
            else begin
               m_drive = 1'b0;
               m_gap   = TURN_CYC;
               m_odat  = 1'b0;
            end
         end else if (DRV_REQ) begin
            m_drive = 1'b1;
            m_gap   = TURN_CYC;
         end
      end else begin
         m_gap = m_gap - 1;
         if (m_gap == 0 && m_drive) m_odat = DRV_DAT;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) model_reset();
         else model_step();
      end
   end

   bit done = 1'b0;

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge CLK);
         if (!done) begin
            chk("m_rdy",   RDY,     m_stable());
            chk("m_mode",  MODE,    m_oen());
            chk("m_oen",   O_EN,    m_oen());
            chk("m_ien",   I_EN,    m_ien());
            chk("m_odat",  O_DAT,   m_odat);
            chk("m_rxval", RX_VAL,  m_rx);
            chk("m_rise",  RX_RISE, m_rise);
            chk("m_fall",  RX_FALL, m_fall);
            chk("en_excl", O_EN & I_EN, 1'b0);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N = 1'b0; DRV_REQ = 1'b0; DRV_DAT = 1'b0; pad = 1'b0;
      repeat (3) cyc();
      RST_N = 1'b1;
      repeat (5) cyc();
      chk("rst_ien", I_EN, 1'b1);
      chk("rst_oen", O_EN, 1'b0);
      chk("rst_rdy", RDY, 1'b1);
      chk("rst_rx",  RX_VAL, 1'b0);

      // enter drive: request seen at edge k
      DRV_REQ = 1'b1; DRV_DAT = 1'b1;
      cyc();                                   // k
      chk("k_ien", I_EN, 1'b0);
      chk("k_rdy", RDY, 1'b0);
      chk("k_oen", O_EN, 1'b0);
      cyc();                                   // k+1
      chk("k1_rdy", RDY, 1'b0);
      cyc();                                   // k+2
      chk("k2_oen",  O_EN, 1'b1);
      chk("k2_mode", MODE, 1'b1);
      chk("k2_rdy",  RDY, 1'b1);
      chk("k2_odat", O_DAT, 1'b1);
      DRV_DAT = 1'b0; cyc();
      chk("odat_0", O_DAT, 1'b0);
      DRV_DAT = 1'b1; cyc();
      chk("odat_1", O_DAT, 1'b1);

      // leave drive: release seen at edge m
      DRV_REQ = 1'b0;
      cyc();                                   // m
      chk("m0_oen",  O_EN, 1'b0);
      chk("m0_odat", O_DAT, 1'b0);
      chk("m0_mode", MODE, 1'b0);
      chk("m0_ien",  I_EN, 1'b0);
      cyc();                                   // m+1
      chk("m1_ien", I_EN, 1'b0);
      cyc();                                   // m+2
      chk("m2_ien", I_EN, 1'b1);
      chk("m2_rdy", RDY, 1'b1);

      // receive rise: stable before edge j, visible after j+4
      repeat (4) cyc();
      pad = 1'b1;
      repeat (4) cyc();                        // j .. j+3
      chk("j3_rx", RX_VAL, 1'b0);
      cyc();                                   // j+4
      chk("j4_rx",   RX_VAL, 1'b1);
      chk("j4_rise", RX_RISE, 1'b1);
      cyc();
      chk("j5_rise", RX_RISE, 1'b0);

      // two-cycle low glitch must be rejected
      pad = 1'b0; cyc(); cyc();
      pad = 1'b1;
      repeat (6) cyc();
      chk("glitch_rx", RX_VAL, 1'b1);

      // receive fall
      pad = 1'b0;
      repeat (4) cyc();
      chk("f3_rx", RX_VAL, 1'b1);
      cyc();
      chk("f4_rx",   RX_VAL, 1'b0);
      chk("f4_fall", RX_FALL, 1'b1);

      // one-cycle request: full turnaround both ways, one drive cycle
      repeat (3) cyc();
      pad = 1'b1; DRV_REQ = 1'b1;
      cyc();                                   // k
      DRV_REQ = 1'b0;
      cyc();                                   // k+1
      cyc();                                   // k+2
      chk("p2_mode", MODE, 1'b1);
      cyc();                                   // k+3
      chk("p3_oen", O_EN, 1'b0);
      cyc();                                   // k+4
      chk("p4_ien", I_EN, 1'b0);
      cyc();                                   // k+5
      chk("p5_ien", I_EN, 1'b1);
      chk("p5_rx",  RX_VAL, 1'b0);
      repeat (4) cyc();                        // k+9
      chk("p9_rx", RX_VAL, 1'b0);
      cyc();                                   // k+10
      chk("p10_rx",   RX_VAL, 1'b1);
      chk("p10_rise", RX_RISE, 1'b1);

      // reset in the middle of drive, between clock edges
      DRV_REQ = 1'b1;
      repeat (4) cyc();
      chk("pre_rst_oen", O_EN, 1'b1);
      #2 RST_N = 1'b0;
      #1;
      chk("arst_oen", O_EN, 1'b0);
      chk("arst_ien", I_EN, 1'b1);
      DRV_REQ = 1'b0;
      cyc(); cyc();
      RST_N = 1'b1;
      cyc();
      chk("rel_mode", MODE, 1'b0);
      chk("rel_ien",  I_EN, 1'b1);
      chk("rel_rx",   RX_VAL, 1'b0);
      repeat (8) cyc();
      chk("rel_rx_late", RX_VAL, 1'b1);

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
